// File: rtl/y86_wb_regfile_if.sv
// W-register to write-back bundle: the retiring instruction's fields flow
// from the W pipeline register into the write-back stage, and the stall
// request flows back to hold the W register.
interface y86_wb_regfile_if #(
    parameter int DW = 32
);
    logic [3:0]    W_stat;
    logic [3:0]    W_icode;
    logic [DW-1:0] W_valE;
    logic [DW-1:0] W_valM;
    logic [3:0]    W_dstE;
    logic [3:0]    W_dstM;
    logic          W_Cnd;
    logic          wb_stall;

    // W pipeline register side: drives the instruction, observes the stall
    modport master (
        output W_stat,
        output W_icode,
        output W_valE,
        output W_valM,
        output W_dstE,
        output W_dstM,
        output W_Cnd,
        input  wb_stall
    );

    // Write-back stage side
    modport slave (
        input  W_stat,
        input  W_icode,
        input  W_valE,
        input  W_valM,
        input  W_dstE,
        input  W_dstM,
        input  W_Cnd,
        output wb_stall
    );
endinterface

// File: rtl/y86_wb_regfile.sv
// Y86 write-back stage: program register file (E and M write ports, two
// combinational decode read ports plus a debug port), sticky processor
// status with a RUN/HALTED state machine, and retired/cycle counters.
module y86_wb_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    y86_wb_regfile_if.slave       w,
    input  logic [3:0]            d_srcA,
    input  logic [3:0]            d_srcB,
    output logic [DW-1:0]         d_rvalA,
    output logic [DW-1:0]         d_rvalB,
    input  logic [2:0]            dbg_addr,
    output logic [DW-1:0]         dbg_data,
    output logic [3:0]            cpu_stat,
    output logic                  cpu_halt,
    output logic [DW-1:0]         instr_count,
    output logic [DW-1:0]         cycle_count
);
    localparam int AW = $clog2(NREG);

    localparam logic [3:0] STAT_AOK   = 4'd1;
    localparam logic [3:0] STAT_HLT   = 4'd2;
    localparam logic [3:0] STAT_ADR   = 4'd3;
    localparam logic [3:0] STAT_INS   = 4'd4;
    localparam logic [3:0] ICODE_NOP  = 4'd1;
    localparam logic [3:0] ICODE_CMOV = 4'd2;
    localparam logic [3:0] NREG_ID    = 4'(NREG);
    localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    stat_reg, stat_next;
    logic [DW-1:0] instr_reg, instr_next;
    logic [DW-1:0] cycle_reg, cycle_next;
    logic          wr_ok;
    logic          we_e;
    logic          we_m;

    // Flattened view of every register's current contents for the read ports
    logic [NREG-1:0][DW-1:0] rf_q;

    // Next-state, status, counter and write-enable decode
    always_comb begin
        state_next = state_reg;
        stat_next  = stat_reg;
        instr_next = instr_reg;
        cycle_next = cycle_reg + ONE;
        wr_ok      = 1'b0;
        we_e       = 1'b0;
        we_m       = 1'b0;
        case (state_reg)
            S_RUN: begin
                wr_ok = (w.W_stat == STAT_AOK);
                if (wr_ok) begin
                    // A not-taken conditional move retires but leaves dstE alone
                    we_e = (w.W_dstE < NREG_ID) &&
                           !((w.W_icode == ICODE_CMOV) && !w.W_Cnd);
                    we_m = (w.W_dstM < NREG_ID);
                    if (w.W_icode != ICODE_NOP) begin
                        instr_next = instr_reg + ONE;
                    end
                end else begin
                    // Any non-AOK status stops the machine; unknown codes read as INS
                    state_next = S_HALTED;
                    if ((w.W_stat == STAT_HLT) || (w.W_stat == STAT_ADR) ||
                        (w.W_stat == STAT_INS)) begin
                        stat_next = w.W_stat;
                    end else begin
                        stat_next = STAT_INS;
                    end
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_HALTED;
            end
        endcase
    end

    // State, status and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_RUN;
            stat_reg  <= STAT_AOK;
            instr_reg <= '0;
            cycle_reg <= '0;
        end else begin
            state_reg <= state_next;
            stat_reg  <= stat_next;
            instr_reg <= instr_next;
            cycle_reg <= cycle_next;
        end
    end

    // One register per program register; M beats E on a shared target
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic          hit_e;
            logic          hit_m;
            logic [DW-1:0] q_reg;

            assign hit_e = we_e && (w.W_dstE[AW-1:0] == AW'(gi));
            assign hit_m = we_m && (w.W_dstM[AW-1:0] == AW'(gi));

            // Per-register write with M priority
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (hit_m) begin
                    q_reg <= w.W_valM;
                end else if (hit_e) begin
                    q_reg <= w.W_valE;
                end
            end

            assign rf_q[gi] = q_reg;
        end
    endgenerate

    // Combinational read; IDs outside the file (0xF = none) read as zero.
    // No bypass: decode forwarding already covers the value being written.
    function automatic logic [DW-1:0] rf_read(input logic [3:0] addr);
        if (addr < NREG_ID) begin
            rf_read = rf_q[addr[AW-1:0]];
        end else begin
            rf_read = '0;
        end
    endfunction

    assign d_rvalA     = rf_read(d_srcA);
    assign d_rvalB     = rf_read(d_srcB);
    assign dbg_data    = rf_read({1'b0, dbg_addr});
    assign cpu_stat    = stat_reg;
    assign cpu_halt    = (state_reg == S_HALTED);
    assign instr_count = instr_reg;
    assign cycle_count = cycle_reg;
    assign w.wb_stall  = (state_reg == S_HALTED) || (w.W_stat != STAT_AOK);
endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed bench for the Y86 write-back stage. Each driven W-stage
// instruction updates a small behavioural model and pushes the expected
// post-edge snapshot; after the edge the snapshot is popped and compared.
module tb_y86_wb_regfile;
    logic clk;
    logic reset;
    logic reset8;

    // Main 32-bit instance
    y86_wb_regfile_if #(.DW(32)) wif ();
    logic [3:0]  d_srcA, d_srcB;
    logic [31:0] d_rvalA, d_rvalB;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [3:0]  cpu_stat;
    logic        cpu_halt;
    logic [31:0] instr_count, cycle_count;

    y86_wb_regfile #(.DW(32), .NREG(8)) dut (
        .clk(clk), .reset(reset), .w(wif.slave),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .cpu_stat(cpu_stat), .cpu_halt(cpu_halt),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    // Reduced-width instance for the cycle counter wrap
    y86_wb_regfile_if #(.DW(8)) wif8 ();
    logic [3:0] s8_srcA, s8_srcB;
    logic [7:0] r8_valA, r8_valB;
    logic [2:0] s8_dbg;
    logic [7:0] r8_dbg;
    logic [3:0] stat8;
    logic       halt8;
    logic [7:0] instr8, cycle8;

    y86_wb_regfile #(.DW(8), .NREG(8)) dut8 (
        .clk(clk), .reset(reset8), .w(wif8.slave),
        .d_srcA(s8_srcA), .d_srcB(s8_srcB), .d_rvalA(r8_valA), .d_rvalB(r8_valB),
        .dbg_addr(s8_dbg), .dbg_data(r8_dbg),
        .cpu_stat(stat8), .cpu_halt(halt8),
        .instr_count(instr8), .cycle_count(cycle8)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] regs;
        logic [3:0]       stat;
        logic             halt;
        logic [31:0]      instr;
        logic [31:0]      cycle;
    } snap_t;

    snap_t m;
    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Drive one W-stage instruction and record the expected post-edge state
    task automatic apply(input logic [3:0] st, input logic [3:0] ic,
                         input logic [31:0] ve, input logic [31:0] vm,
                         input logic [3:0] de, input logic [3:0] dm, input logic cnd);
        wif.W_stat  = st;
        wif.W_icode = ic;
        wif.W_valE  = ve;
        wif.W_valM  = vm;
        wif.W_dstE  = de;
        wif.W_dstM  = dm;
        wif.W_Cnd   = cnd;
        m.cycle = m.cycle + 32'd1;
        if (!m.halt) begin
            if (st == 4'd1) begin
                if (ic != 4'd1) m.instr = m.instr + 32'd1;
                if ((de < 4'd8) && !((ic == 4'd2) && !cnd)) m.regs[de[2:0]] = ve;
                if (dm < 4'd8) m.regs[dm[2:0]] = vm;
            end else begin
                m.halt = 1'b1;
                m.stat = ((st >= 4'd2) && (st <= 4'd4)) ? st : 4'd4;
            end
        end
        exp_q.push_back(m);
        $display("[TB] drive stat=%0d icode=%0d valE=%h valM=%h dstE=%h dstM=%h cnd=%0d",
                 st, ic, ve, vm, de, dm, cnd);
    endtask

    // Pop the expected snapshot and compare every observable register
    task automatic check_pop(input string tag);
        snap_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            d_srcA   = 4'(i);
            d_srcB   = 4'(7 - i);
            #1;
            chk($sformatf("%s.dbg%0d", tag, i), dbg_data, e.regs[i]);
            chk($sformatf("%s.rvalA%0d", tag, i), d_rvalA, e.regs[i]);
            chk($sformatf("%s.rvalB%0d", tag, 7 - i), d_rvalB, e.regs[7 - i]);
        end
        chk({tag, ".stat"},  {28'd0, cpu_stat}, {28'd0, e.stat});
        chk({tag, ".halt"},  {31'd0, cpu_halt}, {31'd0, e.halt});
        chk({tag, ".instr"}, instr_count, e.instr);
        chk({tag, ".cycle"}, cycle_count, e.cycle);
    endtask

    task automatic clock_check(input string tag);
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        m = '0;
        m.stat = 4'd1;
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_pop(tag);
        $display("[TB] reset %s", tag);
    endtask

    initial begin
        reset = 1'b1;
        reset8 = 1'b0;
        d_srcA = 4'd0;
        d_srcB = 4'd0;
        dbg_addr = 3'd0;
        m = '0;
        wif.W_stat = 4'd1; wif.W_icode = 4'd1; wif.W_valE = '0; wif.W_valM = '0;
        wif.W_dstE = 4'hF; wif.W_dstM = 4'hF; wif.W_Cnd = 1'b0;
        wif8.W_stat = 4'd1; wif8.W_icode = 4'd1; wif8.W_valE = '0; wif8.W_valM = '0;
        wif8.W_dstE = 4'hF; wif8.W_dstM = 4'hF; wif8.W_Cnd = 1'b0;
        s8_srcA = 4'd0; s8_srcB = 4'hF; s8_dbg = 3'd0;

        do_reset("reset0");

        // E-port write; old value visible during the write cycle
        apply(4'd1, 4'd3, 32'h12345678, 32'h0, 4'd0, 4'hF, 1'b0);
        d_srcA = 4'd0;
        #1;
        chk("same_cycle_old", d_rvalA, 32'h0);
        chk("stall_run_aok", {31'd0, wif.wb_stall}, 32'd0);
        clock_check("e_write");

        // Conditional move not taken, then taken
        apply(4'd1, 4'd2, 32'd5, 32'h0, 4'd2, 4'hF, 1'b0);
        clock_check("cmov_nt");
        apply(4'd1, 4'd2, 32'd5, 32'h0, 4'd2, 4'hF, 1'b1);
        clock_check("cmov_t");

        // Same target on both ports: M wins
        apply(4'd1, 4'hB, 32'h100, 32'hABC, 4'd4, 4'd4, 1'b0);
        clock_check("popl_esp");

        // M-only write and a dual write to distinct registers
        apply(4'd1, 4'd5, 32'h0, 32'hDEAD_BEEF, 4'hF, 4'd6, 1'b0);
        clock_check("m_only");
        apply(4'd1, 4'hB, 32'h0000_0777, 32'h0000_0999, 4'd7, 4'd5, 1'b0);
        clock_check("dual");

        // Out-of-range read addresses return zero
        d_srcA = 4'd9;
        d_srcB = 4'hF;
        #1;
        chk("srcA_9", d_rvalA, 32'h0);
        chk("srcB_F", d_rvalB, 32'h0);

        // ADR fault: no write, halt with sticky status
        apply(4'd3, 4'd3, 32'd7, 32'h0, 4'd1, 4'hF, 1'b0);
        #1;
        chk("stall_adr", {31'd0, wif.wb_stall}, 32'd1);
        clock_check("adr_halt");

        // Writes after halt are ignored
        apply(4'd1, 4'd3, 32'h55, 32'h66, 4'd1, 4'd3, 1'b0);
        #1;
        chk("stall_halted", {31'd0, wif.wb_stall}, 32'd1);
        clock_check("halted_wr");

        // Ten bubbles while halted
        for (int i = 0; i < 10; i++) begin
            apply(4'd1, 4'd1, 32'h0, 32'h0, 4'hF, 4'hF, 1'b0);
            clock_check($sformatf("bubble_h%0d", i));
        end

        // Reset while halted overrides a pending AOK write
        wif.W_stat = 4'd1; wif.W_icode = 4'd3; wif.W_valE = 32'h33; wif.W_dstE = 4'd3;
        wif.W_dstM = 4'hF;
        do_reset("reset_halted");

        // Bubbles in RUN never count or write
        for (int i = 0; i < 3; i++) begin
            apply(4'd1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 4'hF, 1'b1);
            clock_check($sformatf("bubble_r%0d", i));
        end

        // HLT status
        apply(4'd2, 4'd0, 32'h1, 32'h2, 4'd0, 4'd1, 1'b0);
        clock_check("hlt");
        do_reset("reset2");

        // Unknown status code treated as INS
        apply(4'd1, 4'd3, 32'hCAFE, 32'h0, 4'd3, 4'hF, 1'b0);
        clock_check("pre_bad");
        apply(4'd7, 4'd3, 32'h1111, 32'h2222, 4'd3, 4'd3, 1'b0);
        clock_check("bad_stat");
        apply(4'd4, 4'd3, 32'h0, 32'h0, 4'hF, 4'hF, 1'b0);
        clock_check("stat_frozen");

        // Cycle counter wrap on the 8-bit build
        reset8 = 1'b1;
        @(posedge clk);
        #1;
        reset8 = 1'b0;
        chk("w8_reset", {24'd0, cycle8}, 32'd0);
        repeat (255) @(posedge clk);
        #1;
        chk("w8_max", {24'd0, cycle8}, 32'd255);
        chk("w8_instr", {24'd0, instr8}, 32'd0);
        @(posedge clk);
        #1;
        chk("w8_wrap", {24'd0, cycle8}, 32'd0);
        chk("w8_srcB_F", {24'd0, r8_valB}, 32'd0);
        $display("[TB] wrap cycle8=%0d", cycle8);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
